// File: rtl/ucsbece154_mem_pkg.sv
// Shared definitions for the multi-port data memory.
// Provides word/byte geometry, the default window base, the init/run state
// type and the helper that clips the window end to the data segment limit.
package ucsbece154_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTES  = 4;

  localparam logic [31:0] DEFAULT_DATA_START = 32'h1000_0000;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  // 33-bit so a window that ends exactly at 4 GiB still compares correctly.
  function automatic logic [32:0] min_addr(input logic [32:0] x, input logic [32:0] y);
    return (x < y) ? x : y;
  endfunction

  function automatic logic [32:0] data_end(input logic [31:0] start, input int unsigned size);
    return min_addr({1'b0, start} + 33'(4 * size), 33'h0_8000_0000);
  endfunction

endpackage

// File: rtl/ucsbece154_dmem_decode.sv
// Per-port address decoder (purely combinational).
//   a_i          byte address of the request
//   in_range_o   address falls inside [DATA_START, DATA_END)
//   misaligned_o low two address bits are non-zero
//   index_o      word index into the array (low address bits ignored)
module ucsbece154_dmem_decode
  import ucsbece154_mem_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 64,
  parameter logic [31:0] DATA_START = DEFAULT_DATA_START,
  localparam int unsigned IdxW      = $clog2(DATA_SIZE)
) (
  input  logic [31:0]     a_i,
  output logic            in_range_o,
  output logic            misaligned_o,
  output logic [IdxW-1:0] index_o
);

  localparam logic [32:0] DataEnd = data_end(DATA_START, DATA_SIZE);

  assign in_range_o   = (a_i >= DATA_START) && ({1'b0, a_i} < DataEnd);
  assign misaligned_o = (a_i[1:0] != 2'b00);
  // Modulo subtraction is exact for in-range addresses; out-of-range ones never use it.
  assign index_o      = a_i[2 +: IdxW] - DATA_START[2 +: IdxW];

endmodule

// File: rtl/ucsbece154_dmem_mp.sv
// Multi-port data memory with synchronous reads and byte-enable writes.
//   clk, reset   rising-edge clock, synchronous active-high reset
//   ready_o      high once the optional zero-clear has finished (RUN)
//   re_i/we_i    per-port read / write requests
//   be_i         per-port byte enables, port p on [4p+3:4p]
//   a_i, wd_i    per-port byte address and write data, port p on [32p+31:32p]
//   rd_o         per-port registered read data, held between reads
//   rvalid_o     one-cycle pulse when a port's rd_o slice was updated
//   err_o        one-cycle pulse for a misaligned or out-of-range request
// Same-word writes resolve per byte with the highest port winning; reads in
// the same cycle see the merged post-write word.
module ucsbece154_dmem_mp
  import ucsbece154_mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned DATA_SIZE      = 64,
  parameter logic [31:0] DATA_START     = DEFAULT_DATA_START,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      ready_o,
  input  logic [NUM_PORTS-1:0]      re_i,
  input  logic [NUM_PORTS-1:0]      we_i,
  input  logic [4*NUM_PORTS-1:0]    be_i,
  input  logic [32*NUM_PORTS-1:0]   a_i,
  input  logic [32*NUM_PORTS-1:0]   wd_i,
  output logic [32*NUM_PORTS-1:0]   rd_o,
  output logic [NUM_PORTS-1:0]      rvalid_o,
  output logic [NUM_PORTS-1:0]      err_o
);

  localparam int unsigned IdxW = $clog2(DATA_SIZE);

  state_e                    state_q, state_d;
  logic [IdxW-1:0]           clr_ptr_q, clr_ptr_d;
  logic                      ready_q, ready_d;
  logic [32*NUM_PORTS-1:0]   rd_q, rd_d;
  logic [NUM_PORTS-1:0]      rvalid_q, rvalid_d;
  logic [NUM_PORTS-1:0]      err_q, err_d;
  logic [WORD_W-1:0]         mem_q [DATA_SIZE];
  logic [WORD_W-1:0]         mem_d [DATA_SIZE];

  logic [NUM_PORTS-1:0]      in_range;
  logic [NUM_PORTS-1:0]      misaligned;
  logic [IdxW-1:0]           index [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
    ucsbece154_dmem_decode #(
      .DATA_SIZE  (DATA_SIZE),
      .DATA_START (DATA_START)
    ) u_dec (
      .a_i          (a_i[32*p +: 32]),
      .in_range_o   (in_range[p]),
      .misaligned_o (misaligned[p]),
      .index_o      (index[p])
    );
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_d     = mem_q;
    rd_d      = rd_q;
    rvalid_d  = '0;
    err_d     = '0;
    unique case (state_q)
      StInit: begin
        if (CLEAR_ON_RESET) begin
          mem_d[clr_ptr_q] = '0;
          clr_ptr_d        = clr_ptr_q + 1'b1;
          if (clr_ptr_q == IdxW'(DATA_SIZE - 1)) state_d = StRun;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Ascending port order lets the highest-numbered writer own each byte.
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          if (we_i[p] && in_range[p]) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
              if (be_i[4*p + b]) mem_d[index[p]][8*b +: 8] = wd_i[32*p + 8*b +: 8];
            end
          end
        end
        // Reads sample the merged array: write-first forwarding.
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          if (re_i[p]) begin
            rvalid_d[p]      = 1'b1;
            rd_d[32*p +: 32] = in_range[p] ? mem_d[index[p]] : '0;
          end
          err_d[p] = (re_i[p] | (we_i[p] & (|be_i[4*p +: 4]))) &
                     (misaligned[p] | ~in_range[p]);
        end
      end
      default: state_d = StInit;
    endcase
    ready_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StInit;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      rd_q      <= '0;
      rvalid_q  <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      rd_q      <= rd_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  // Array has no reset value; a reset cycle simply commits nothing.
  always_ff @(posedge clk) begin
    if (!reset) mem_q <= mem_d;
  end

  assign ready_o  = ready_q;
  assign rd_o     = rd_q;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_ucsbece154_dmem_mp.sv
module tb_ucsbece154_dmem_mp;

  localparam int NP = 2;
  localparam int DS = 64;
  localparam logic [31:0] START = 32'h1000_0000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ready;
  logic [NP-1:0]     re, we, rvalid, err;
  logic [4*NP-1:0]   be;
  logic [32*NP-1:0]  a, wd, rd;

  always #5 clk = ~clk;

  ucsbece154_dmem_mp #(
    .NUM_PORTS      (NP),
    .DATA_SIZE      (DS),
    .DATA_START     (START),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ready_o  (ready),
    .re_i     (re),
    .we_i     (we),
    .be_i     (be),
    .a_i      (a),
    .wd_i     (wd),
    .rd_o     (rd),
    .rvalid_o (rvalid),
    .err_o    (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mmem [DS];
  int          cnt;
  bit          chk_en = 1'b0;
  bit          run;
  logic        exp_ready;
  logic [NP-1:0] exp_rvalid, exp_err;
  logic [31:0] exp_rd [NP];

  function automatic bit in_rng(input logic [31:0] ad);
    longint unsigned lo, hi;
    lo = 64'(START);
    hi = lo + 64'(4 * DS);
    if (hi > 64'h8000_0000) hi = 64'h8000_0000;
    return (64'(ad) >= lo) && (64'(ad) < hi);
  endfunction

  function automatic int widx(input logic [31:0] ad);
    return int'((ad - START) >> 2);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cnt        = 0;
      exp_ready  = 1'b0;
      exp_rvalid = '0;
      exp_err    = '0;
      for (int p = 0; p < NP; p++) exp_rd[p] = '0;
      for (int i = 0; i < DS; i++) mmem[i] = '0;  // clear completes before any access
      chk_en = 1'b1;
    end else begin
      run        = (cnt >= DS);
      exp_rvalid = '0;
      exp_err    = '0;
      if (run) begin
        for (int p = 0; p < NP; p++) begin
          if (we[p] && in_rng(a[32*p +: 32])) begin
            for (int b = 0; b < 4; b++)
              if (be[4*p + b]) mmem[widx(a[32*p +: 32])][8*b +: 8] = wd[32*p + 8*b +: 8];
          end
        end
        for (int p = 0; p < NP; p++) begin
          if (re[p]) begin
            exp_rvalid[p] = 1'b1;
            exp_rd[p] = in_rng(a[32*p +: 32]) ? mmem[widx(a[32*p +: 32])] : 32'h0;
          end
          if ((re[p] || (we[p] && be[4*p +: 4] != 4'h0)) &&
              (a[32*p +: 2] != 2'b00 || !in_rng(a[32*p +: 32])))
            exp_err[p] = 1'b1;
        end
      end
      if (cnt < DS) cnt++;
      exp_ready = (cnt >= DS);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ready", {31'b0, ready}, {31'b0, exp_ready});
      for (int p = 0; p < NP; p++) begin
        check($sformatf("model_rvalid%0d", p), {31'b0, rvalid[p]}, {31'b0, exp_rvalid[p]});
        check($sformatf("model_err%0d", p), {31'b0, err[p]}, {31'b0, exp_err[p]});
        check($sformatf("model_rd%0d", p), rd[32*p +: 32], exp_rd[p]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    re = '0; we = '0; be = '0; a = '0; wd = '0;
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input logic [3:0] b,
                          input logic [31:0] ad, input logic [31:0] d);
    re[p] = r; we[p] = w; be[4*p +: 4] = b; a[32*p +: 32] = ad; wd[32*p +: 32] = d;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k <= 5) return START + 32'(4 * $urandom_range(0, 7));
    if (k == 6) return START + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
    if (k == 7) return START + 32'h100 + 32'(4 * $urandom_range(0, 3));
    if (k == 8) return (($urandom_range(0, 1) == 0) ? START - 32'd4 : START + 32'hFC);
    return $urandom;
  endfunction

  task automatic wait_init();
    for (int k = 1; k <= DS; k++) begin
      cyc();
      if (k == DS - 1) check("ready_low_before", {31'b0, ready}, 32'd0);
      if (k == DS)     check("ready_rises", {31'b0, ready}, 32'd1);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    wait_init();

    // Cleared word reads zero
    idle(); set_port(0, 1, 0, 4'h0, 32'h1000_00FC, 0); cyc();
    check("init_rvalid", {31'b0, rvalid[0]}, 32'd1);
    check("init_rd", rd[31:0], 32'h0);

    // Byte-enable write
    idle(); set_port(0, 0, 1, 4'hF, 32'h1000_0008, 32'h1122_3344); cyc();
    check("wr_rvalid_low", {30'b0, rvalid}, 32'd0);
    idle(); set_port(0, 0, 1, 4'b0101, 32'h1000_0008, 32'hAABB_CCDD); cyc();
    idle(); set_port(0, 1, 0, 4'h0, 32'h1000_0008, 0); cyc();
    check("byte_write", rd[31:0], 32'h11BB_33DD);

    // Collision: port1 owns its bytes
    idle();
    set_port(0, 0, 1, 4'hF, 32'h1000_0010, 32'h1111_1111);
    set_port(1, 0, 1, 4'b0011, 32'h1000_0010, 32'h2222_2222);
    cyc();
    idle(); set_port(0, 1, 0, 4'h0, 32'h1000_0010, 0); cyc();
    check("collision", rd[31:0], 32'h1111_2222);

    // Read-during-write forwarding
    idle();
    set_port(0, 0, 1, 4'hF, 32'h1000_0010, 32'hDEAD_BEEF);
    set_port(1, 1, 0, 4'h0, 32'h1000_0010, 0);
    cyc();
    check("rdw_data", rd[63:32], 32'hDEAD_BEEF);
    check("rdw_rvalid", {31'b0, rvalid[1]}, 32'd1);

    // Errors
    idle(); set_port(0, 1, 0, 4'h0, 32'h1000_0100, 0); cyc();
    check("oor_rd", rd[31:0], 32'h0);
    check("oor_err", {31'b0, err[0]}, 32'd1);
    idle(); set_port(1, 0, 1, 4'hF, 32'h1000_0006, 32'h1234_5678); cyc();
    check("mis_err", {30'b0, err}, 32'd2);
    idle(); set_port(0, 1, 0, 4'h0, 32'h1000_0004, 0); cyc();
    check("mis_write", rd[31:0], 32'h1234_5678);
    check("aligned_no_err", {30'b0, err}, 32'd0);
    idle(); set_port(0, 0, 1, 4'hF, 32'h0FFF_FFFC, 32'hFFFF_FFFF); cyc();
    check("below_err", {30'b0, err}, 32'd1);
    idle(); set_port(1, 0, 1, 4'h0, 32'h1000_0003, 32'hFFFF_FFFF); cyc();
    check("be0_no_err", {30'b0, err}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      idle();
      for (int p = 0; p < NP; p++) begin
        set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 4'($urandom), rand_addr(), $urandom);
      end
      cyc();
    end

    // Reset mid-read
    idle(); set_port(0, 1, 0, 4'h0, 32'h1000_0008, 0);
    reset = 1'b1;
    cyc();
    check("rst_rvalid", {30'b0, rvalid}, 32'd0);
    check("rst_ready", {31'b0, ready}, 32'd0);
    idle();
    reset = 1'b0;
    wait_init();
    idle(); set_port(0, 1, 0, 4'h0, 32'h1000_0008, 0); set_port(1, 1, 0, 4'h0, 32'h1000_0010, 0);
    cyc();
    check("rst_clear0", rd[31:0], 32'h0);
    check("rst_clear1", rd[63:32], 32'h0);
    idle(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
